// File: rtl/gate_vec_checker.sv
// Stimulus sequencer and scoreboard for the two-input gate bank: sweeps A/B
// through all four combinations, checks Y after a settle window, reports a verdict.
module gate_vec_checker #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned PASSES      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] Y,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [1:0] fail_vec,
  output logic [3:0] fail_bits
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    vec_q, vec_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [PW-1:0] pass_cnt_q, pass_cnt_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          first_fail_q, first_fail_d;
  logic [1:0]    fail_vec_q, fail_vec_d;
  logic [3:0]    fail_bits_q, fail_bits_d;
  logic          pass_q, pass_d;

  logic [3:0] exp_y;
  logic       mismatch;
  logic       drive_ab;

  // A = vec[1], B = vec[0]; bit order matches the gate bank's Y[3:0].
  assign exp_y = {~vec_q[1], vec_q[1] ^ vec_q[0], vec_q[1] | vec_q[0], vec_q[1] & vec_q[0]};

  // Case inequality so an X/Z on Y is scored as a mismatch rather than ignored.
  assign mismatch = (Y !== exp_y);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case leaves it unassigned (no latches).
    state_d      = state_q;
    vec_d        = vec_q;
    hold_d       = hold_q;
    pass_cnt_d   = pass_cnt_q;
    err_cnt_d    = err_cnt_q;
    first_fail_d = first_fail_q;
    fail_vec_d   = fail_vec_q;
    fail_bits_d  = fail_bits_q;
    pass_d       = pass_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_SETTLE;
          vec_d        = '0;
          hold_d       = '0;
          pass_cnt_d   = '0;
          err_cnt_d    = '0;
          first_fail_d = 1'b0;
          fail_vec_d   = '0;
          fail_bits_d  = '0;
          pass_d       = 1'b0;
        end
      end

      S_SETTLE: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_CHECK;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      S_CHECK: begin
        if (mismatch) begin
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          if (!first_fail_q) begin
            first_fail_d = 1'b1;
            fail_vec_d   = vec_q;
            fail_bits_d  = Y ^ exp_y;
          end
        end

        if (vec_q != 2'd3) begin
          vec_d   = vec_q + 2'd1;
          state_d = S_SETTLE;
        end else if (pass_cnt_q != PASS_LAST) begin
          vec_d      = '0;
          pass_cnt_d = pass_cnt_q + 1'b1;
          state_d    = S_SETTLE;
        end else begin
          // Verdict is registered here so it is already valid in the DONE cycle.
          state_d = S_DONE;
          pass_d  = (err_cnt_d == 8'd0);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      hold_q       <= '0;
      pass_cnt_q   <= '0;
      err_cnt_q    <= '0;
      first_fail_q <= 1'b0;
      fail_vec_q   <= '0;
      fail_bits_q  <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      hold_q       <= hold_d;
      pass_cnt_q   <= pass_cnt_d;
      err_cnt_q    <= err_cnt_d;
      first_fail_q <= first_fail_d;
      fail_vec_q   <= fail_vec_d;
      fail_bits_q  <= fail_bits_d;
      pass_q       <= pass_d;
    end
  end

  assign drive_ab  = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign A         = drive_ab & vec_q[1];
  assign B         = drive_ab & vec_q[0];
  assign busy      = drive_ab;
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign fail_vec  = fail_vec_q;
  assign fail_bits = fail_bits_q;

endmodule

// File: tb/tb_gate_vec_checker.sv
// Directed bench for gate_vec_checker: three instances with different sweep settings,
// each looped back through a gate-bank model that can be golden or faulted.
module tb_gate_vec_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start_i;
  logic [2:0] a_o, b_o, busy_o, done_o, pass_o;
  logic [7:0] err_o [3];
  logic [1:0] fv_o  [3];
  logic [3:0] fb_o  [3];
  logic [3:0] y_i   [3];
  int         mode  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] golden(input logic [1:0] v);
    return {~v[1], v[1] ^ v[0], v[1] | v[0], v[1] & v[0]};
  endfunction

  // 0: golden bank, 1: Y[2] stuck at 0, 2: Y stuck at 0000.
  function automatic logic [3:0] bank(input logic [1:0] v, input int m);
    logic [3:0] g;
    g = golden(v);
    case (m)
      1:       return g & 4'b1011;
      2:       return 4'b0000;
      default: return g;
    endcase
  endfunction

  assign y_i[0] = bank({a_o[0], b_o[0]}, mode[0]);
  assign y_i[1] = bank({a_o[1], b_o[1]}, mode[1]);
  assign y_i[2] = bank({a_o[2], b_o[2]}, mode[2]);

  gate_vec_checker #(.HOLD_CYCLES(2), .PASSES(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_i[0]), .Y(y_i[0]),
    .A(a_o[0]), .B(b_o[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .err_cnt(err_o[0]), .fail_vec(fv_o[0]), .fail_bits(fb_o[0])
  );

  gate_vec_checker #(.HOLD_CYCLES(2), .PASSES(3)) dut1 (
    .clk(clk), .rst(rst), .start(start_i[1]), .Y(y_i[1]),
    .A(a_o[1]), .B(b_o[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .err_cnt(err_o[1]), .fail_vec(fv_o[1]), .fail_bits(fb_o[1])
  );

  gate_vec_checker #(.HOLD_CYCLES(1), .PASSES(70)) dut2 (
    .clk(clk), .rst(rst), .start(start_i[2]), .Y(y_i[2]),
    .A(a_o[2]), .B(b_o[2]), .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
    .err_cnt(err_o[2]), .fail_vec(fv_o[2]), .fail_bits(fb_o[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; returns positioned in cycle 0 of the run.
  task automatic launch(input int idx);
    start_i[idx] = 1'b1;
    tick();
    start_i[idx] = 1'b0;
  endtask

  // Called in cycle 0; walks the run cycle by cycle and ends in the DONE cycle.
  task automatic sweep(input int idx, input int h, input int p,
                       input int e_err, input int e_fv, input int e_fb, input int e_pass);
    int n;
    int exp_cnt;
    int k;
    logic [1:0] v;
    n = 4 * p * (h + 1);
    exp_cnt = 0;
    for (int c = 0; c < n; c++) begin
      k = c / (h + 1);
      v = 2'(k % 4);
      if (c == 0) begin
        check("start_clears_pass", 32'(pass_o[idx]), 32'd0);
        check("start_clears_fail_vec", 32'(fv_o[idx]), 32'd0);
        check("start_clears_fail_bits", 32'(fb_o[idx]), 32'd0);
      end
      check("busy_in_run", 32'(busy_o[idx]), 32'd1);
      check("no_early_done", 32'(done_o[idx]), 32'd0);
      check("ab_vector", 32'({a_o[idx], b_o[idx]}), 32'(v));
      check("err_running", 32'(err_o[idx]), 32'((exp_cnt > 255) ? 255 : exp_cnt));
      if ((c % (h + 1)) == h && bank(v, mode[idx]) !== golden(v)) begin
        exp_cnt++;
      end
      tick();
    end
    check("done_pulse", 32'(done_o[idx]), 32'd1);
    check("busy_low_at_done", 32'(busy_o[idx]), 32'd0);
    check("ab_idle_at_done", 32'({a_o[idx], b_o[idx]}), 32'd0);
    check("pass_verdict", 32'(pass_o[idx]), 32'(e_pass));
    check("err_cnt_final", 32'(err_o[idx]), 32'(e_err));
    check("fail_vec_final", 32'(fv_o[idx]), 32'(e_fv));
    check("fail_bits_final", 32'(fb_o[idx]), 32'(e_fb));
  endtask

  initial begin
    rst     = 1'b1;
    start_i = '0;
    mode[0] = 0;
    mode[1] = 0;
    mode[2] = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) begin
      check("rst_busy", 32'(busy_o[i]), 32'd0);
      check("rst_done", 32'(done_o[i]), 32'd0);
      check("rst_ab", 32'({a_o[i], b_o[i]}), 32'd0);
    end
    check("rst_pass", 32'(pass_o[0]), 32'd0);
    check("rst_err_cnt", 32'(err_o[0]), 32'd0);
    check("rst_fail_vec", 32'(fv_o[0]), 32'd0);
    check("rst_fail_bits", 32'(fb_o[0]), 32'd0);

    // Golden bank, H=2, P=1: done in cycle 12, clean verdict.
    launch(0);
    sweep(0, 2, 1, 0, 0, 0, 1);
    tick();
    check("done_one_cycle", 32'(done_o[0]), 32'd0);
    check("pass_held", 32'(pass_o[0]), 32'd1);

    // Y[2] stuck at 0: vectors 01 and 10 fail.
    mode[0] = 1;
    launch(0);
    sweep(0, 2, 1, 2, 1, 4'b0100, 0);
    tick();

    // Same fault over three sweeps: done in cycle 36.
    mode[1] = 1;
    launch(1);
    sweep(1, 2, 3, 6, 1, 4'b0100, 0);
    tick();
    check("p3_done_one_cycle", 32'(done_o[1]), 32'd0);

    // Y forced to 0000 over 280 vectors: counter saturates.
    mode[2] = 2;
    launch(2);
    sweep(2, 1, 70, 255, 0, 4'b1000, 0);
    tick();

    // Reset during SETTLE of vector 2 aborts the run without a done pulse.
    mode[0] = 1;
    launch(0);
    repeat (7) tick();
    check("pre_rst_err", 32'(err_o[0]), 32'd1);
    check("pre_rst_ab", 32'({a_o[0], b_o[0]}), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy_o[0]), 32'd0);
    check("abort_ab", 32'({a_o[0], b_o[0]}), 32'd0);
    check("abort_err", 32'(err_o[0]), 32'd0);
    check("abort_fail_vec", 32'(fv_o[0]), 32'd0);
    check("abort_done", 32'(done_o[0]), 32'd0);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("abort_no_done", 32'(done_o[0]), 32'd0);
    end
    mode[0] = 0;
    launch(0);
    sweep(0, 2, 1, 0, 0, 0, 1);
    tick();

    // start held high: faulted run, one IDLE cycle, then a clean second run.
    mode[0] = 1;
    start_i[0] = 1'b1;
    tick();
    sweep(0, 2, 1, 2, 1, 4'b0100, 0);
    mode[0] = 0;
    tick();
    check("gap_busy", 32'(busy_o[0]), 32'd0);
    check("gap_done", 32'(done_o[0]), 32'd0);
    check("gap_err_held", 32'(err_o[0]), 32'd2);
    check("gap_pass_held", 32'(pass_o[0]), 32'd0);
    tick();
    sweep(0, 2, 1, 0, 0, 0, 1);
    start_i[0] = 1'b0;
    tick();
    check("after_held_busy", 32'(busy_o[0]), 32'd0);
    tick();
    check("no_third_run", 32'(busy_o[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
